move_input_conditioner: RTL and testbench
=========================================

// Module: move_input_conditioner
// PURPOSE
//  Upstream of the 2048 game FSM. Turns four raw, bouncing, asynchronous push-buttons
//  into clean single-cycle move pulses (up/down/left/right) that drive the FSM's
//  up/down/left/right inputs. Synchronises and debounces each button, detects presses,
//  arbitrates to one move at a time and holds it until the FSM reports q_Wait (ready).
// PARAMETERS
//  DEBOUNCE_CYCLES  500000  consecutive stable cycles before a level change is accepted (5 ms @100 MHz)
//  SYNC_STAGES      2       synchroniser flops per button (>=2)
// PORTS
//  Clk        in   1  system clock, all logic on posedge
//  Reset_n    in   1  asynchronous, active-low reset
//  BtnU_raw   in   1  raw up button, asynchronous, active-high
//  BtnD_raw   in   1  raw down button
//  BtnL_raw   in   1  raw left button
//  BtnR_raw   in   1  raw right button
//  ready      in   1  FSM in WAIT (q_Wait); a move may be issued
//  up         out  1  one-cycle move pulse to FSM
//  down       out  1  one-cycle move pulse to FSM
//  left       out  1  one-cycle move pulse to FSM
//  right      out  1  one-cycle move pulse to FSM
//  btn_level  out  4  debounced levels {R,L,D,U}, for LEDs/debug
//  dropped    out  1  one-cycle pulse: a press was discarded (move already pending)
// BEHAVIOUR
//  - Reset (Reset_n=0, async): all outputs 0, sync flops 0, counters 0, debounced levels 0, state IDLE.
//    Reset asserted mid-debounce or mid-pending discards everything; no pulse on reset release.
//  - Per button: SYNC_STAGES-flop sync; counter increments while synced != debounced level,
//    clears to 0 whenever they match; when counter == DEBOUNCE_CYCLES-1, debounced level takes
//    the synced value and counter clears. Counter width $clog2(DEBOUNCE_CYCLES); saturation never needed.
//  - Press = registered rising edge of debounced level (one cycle). Releases generate nothing; a held
//    button yields exactly one press (no auto-repeat).
//  - Simultaneous presses in one cycle: priority U > D > L > R (matches FSM priority); others dropped,
//    dropped=1 for that cycle.
//  - FSM states: IDLE, PENDING, ISSUED.
//    IDLE: press -> latch one-hot dir, -> PENDING.
//    PENDING: if ready=1 -> assert matching output for exactly one cycle, -> ISSUED; else hold.
//      Any new press while PENDING or ISSUED is discarded, dropped=1.
//    ISSUED: wait for ready=0 (FSM left WAIT); then -> IDLE. If ready stays 1 (e.g. WIN/LOSE never
//      leave), stay ISSUED; no further moves issued until ready falls.
//  - Outputs are registered; at most one of up/down/left/right is 1 in any cycle; each pulse exactly 1 cycle.
//  - Latency: raw button stable-high at cycle 0 with ready=1 and state IDLE -> pulse in cycle
//    SYNC_STAGES + DEBOUNCE_CYCLES + 2. ready rising while PENDING -> pulse next cycle.
//  - Bounce: any glitch shorter than DEBOUNCE_CYCLES resets that button's counter; no level change.
//  - btn_level reflects debounced levels directly (registered, no extra latency).
// STRUCTURE
//  - Shared package move_pkg: DIR_U/D/L/R one-hot 4-bit constants ({R,L,D,U} bit order),
//    state encodings IDLE/PENDING/ISSUED, default DEBOUNCE_CYCLES.
//  - Sub-module button_debouncer (sync + counter + debounced level + rise pulse), instantiated 4x;
//    arbitration/pending FSM lives in move_input_conditioner.
// TESTING  (benches use DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
//  - Clean press BtnU held 20 cycles, ready=1 -> up=1 exactly in cycle 8 only; down/left/right stay 0.
//  - BtnL toggling high 3 cycles / low 1 cycle for 16 cycles then low -> no pulse, btn_level stays 0.
//  - BtnR press with ready=0; raise ready 10 cycles later -> right=1 the cycle after ready rises, once.
//  - BtnU and BtnL rise same cycle, ready=1 -> up pulse only, dropped=1 once at the press cycle.
//  - Press D, pulse issued, ready held 1; press U -> no pulse, dropped=1; drop ready then press U -> up pulse.
//  - Reset_n low 2 cycles in middle of BtnD debounce -> all outputs 0 immediately; no pulse after release
//    until button released and re-pressed.

Source files
------------

// File: rtl/move_pkg.sv
// Shared constants for the 2048 move input path: direction one-hots ({R,L,D,U}),
// arbiter state encoding and the default debounce window.
package move_pkg;
  localparam int NUM_BTNS            = 4;
  localparam int DEBOUNCE_CYCLES_DEF = 500000;

  localparam logic [NUM_BTNS-1:0] DIR_U = 4'b0001;
  localparam logic [NUM_BTNS-1:0] DIR_D = 4'b0010;
  localparam logic [NUM_BTNS-1:0] DIR_L = 4'b0100;
  localparam logic [NUM_BTNS-1:0] DIR_R = 4'b1000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    ISSUED  = 2'd2
  } move_state_e;

  // Lowest set bit wins, which gives U > D > L > R for the {R,L,D,U} order.
  function automatic logic [NUM_BTNS-1:0] prio_pick(input logic [NUM_BTNS-1:0] req);
    return req & (~req + 4'd1);
  endfunction
endpackage

// File: rtl/move_input_conditioner_if.sv
// Button/move bundle between the board-side stimulus and the move conditioner.
interface move_input_conditioner_if;
  logic       BtnU_raw;
  logic       BtnD_raw;
  logic       BtnL_raw;
  logic       BtnR_raw;
  logic       ready;
  logic       up;
  logic       down;
  logic       left;
  logic       right;
  logic [3:0] btn_level;
  logic       dropped;

  modport master (
    output BtnU_raw, BtnD_raw, BtnL_raw, BtnR_raw, ready,
    input  up, down, left, right, btn_level, dropped
  );
  modport slave (
    input  BtnU_raw, BtnD_raw, BtnL_raw, BtnR_raw, ready,
    output up, down, left, right, btn_level, dropped
  );
endinterface

// File: rtl/move_input_conditioner_button_debouncer.sv
// One push-button: synchroniser, stability counter, debounced level and a
// single-cycle press flag on the debounced rising edge.
module button_debouncer
  import move_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int SYNC_STAGES     = 2
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic raw_i,
  output logic level_o,
  output logic press_o
);
  localparam int CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int FILL_W = $clog2(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [FILL_W-1:0]      fill_q, fill_d;
  logic                   level_q, level_d;
  logic                   level_dly_q, level_dly_d;
  logic                   armed_q, armed_d;
  logic                   synced, primed;

  assign synced = sync_q[SYNC_STAGES-1];
  assign primed = (fill_q == FILL_W'(SYNC_STAGES));

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], raw_i};
    cnt_d       = '0;
    level_d     = level_q;
    level_dly_d = level_q;
    fill_d      = primed ? fill_q : fill_q + 1'b1;
    // A button held through reset must be seen released before it may press.
    armed_d     = armed_q | (primed & ~synced);
    if (synced != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) level_d = synced;
      else                                     cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync_q      <= '0;
      cnt_q       <= '0;
      fill_q      <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      cnt_q       <= cnt_d;
      fill_q      <= fill_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      armed_q     <= armed_d;
    end
  end

  assign level_o = level_q;
  assign press_o = level_q & ~level_dly_q & armed_q;
endmodule

// File: rtl/move_input_conditioner.sv
// Four debounced buttons feeding a one-move-at-a-time arbiter that hands a
// single-cycle move pulse to the game FSM once it reports ready.
module move_input_conditioner
  import move_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int SYNC_STAGES     = 2
) (
  input logic                     Clk,
  input logic                     Reset_n,
  move_input_conditioner_if.slave bus
);
  logic [NUM_BTNS-1:0] raw, level, press, pick;
  logic [NUM_BTNS-1:0] dir_q, dir_d, mv_q, mv_d;
  logic                drop_q, drop_d;
  move_state_e         state_q, state_d;

  assign raw = {bus.BtnR_raw, bus.BtnL_raw, bus.BtnD_raw, bus.BtnU_raw};

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_db (
      .Clk    (Clk),
      .Reset_n(Reset_n),
      .raw_i  (raw[i]),
      .level_o(level[i]),
      .press_o(press[i])
    );
  end

  assign pick = prio_pick(press);

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    mv_d    = '0;
    drop_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|press) begin
          dir_d   = pick;
          drop_d  = |(press & ~pick);
          state_d = PENDING;
        end
      end
      PENDING: begin
        drop_d = |press;
        if (bus.ready) begin
          mv_d    = dir_q;
          state_d = ISSUED;
        end
      end
      ISSUED: begin
        // Stay here until the game FSM leaves WAIT, so one press = one move.
        drop_d = |press;
        if (!bus.ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      dir_q   <= '0;
      mv_q    <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      mv_q    <= mv_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.up        = mv_q[0];
  assign bus.down      = mv_q[1];
  assign bus.left      = mv_q[2];
  assign bus.right     = mv_q[3];
  assign bus.btn_level = level;
  assign bus.dropped   = drop_q;
endmodule

// File: tb/tb_move_input_conditioner.sv
// Directed bench for move_input_conditioner with a 4-cycle debounce window.
module tb_move_input_conditioner;
  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  move_input_conditioner_if bus ();

  move_input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .SYNC_STAGES    (2)
  ) dut (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .bus    (bus)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // moves observed as {R,L,D,U}
  task automatic chk_mv(input string tag, input logic [3:0] exp);
    chk(tag, {4'h0, bus.right, bus.left, bus.down, bus.up}, {4'h0, exp});
  endtask

  task automatic set_btn(input logic [3:0] b);
    bus.BtnU_raw = b[0];
    bus.BtnD_raw = b[1];
    bus.BtnL_raw = b[2];
    bus.BtnR_raw = b[3];
  endtask

  task automatic do_reset();
    set_btn(4'b0000);
    bus.ready = 1'b0;
    Reset_n   = 1'b0;
    tick();
    tick();
    Reset_n = 1'b1;
    repeat (5) tick();
  endtask

  initial begin
    set_btn(4'b0000);
    bus.ready = 1'b0;
    tick();
    tick();
    chk_mv("reset_moves", 4'b0000);
    chk("reset_level", {4'h0, bus.btn_level}, 8'h00);
    chk("reset_dropped", {7'h0, bus.dropped}, 8'h00);
    Reset_n = 1'b1;
    repeat (5) tick();

    // clean U press, ready high: pulse in cycle 8 only
    bus.ready = 1'b1;
    set_btn(4'b0001);
    for (int c = 1; c <= 20; c++) begin
      tick();
      chk_mv("clean_u_mv", (c == 8) ? 4'b0001 : 4'b0000);
      chk("clean_u_lvl", {4'h0, bus.btn_level}, (c >= 6) ? 8'h01 : 8'h00);
    end

    // bouncing L: 3 high / 1 low for 16 cycles, never accepted
    do_reset();
    bus.ready = 1'b1;
    for (int c = 0; c < 24; c++) begin
      set_btn((c < 16 && (c % 4) != 3) ? 4'b0100 : 4'b0000);
      tick();
      chk_mv("bounce_mv", 4'b0000);
      chk("bounce_lvl", {4'h0, bus.btn_level}, 8'h00);
    end

    // R pressed with ready low, ready rises at cycle 10 -> right in cycle 11
    do_reset();
    set_btn(4'b1000);
    for (int c = 1; c <= 20; c++) begin
      tick();
      chk_mv("pend_r_mv", (c == 11) ? 4'b1000 : 4'b0000);
      chk("pend_r_drop", {7'h0, bus.dropped}, 8'h00);
      if (c == 10) bus.ready = 1'b1;
    end

    // U and L together: U wins, the L press is dropped
    do_reset();
    bus.ready = 1'b1;
    set_btn(4'b0101);
    for (int c = 1; c <= 14; c++) begin
      tick();
      chk_mv("simul_mv", (c == 8) ? 4'b0001 : 4'b0000);
      chk("simul_drop", {7'h0, bus.dropped}, (c == 7) ? 8'h01 : 8'h00);
      chk("simul_lvl", {4'h0, bus.btn_level}, (c >= 6) ? 8'h05 : 8'h00);
    end

    // D issued, ready held high, then U is dropped; after ready falls U issues
    do_reset();
    bus.ready = 1'b1;
    set_btn(4'b0010);
    for (int c = 1; c <= 12; c++) begin
      tick();
      chk_mv("issued_d_mv", (c == 8) ? 4'b0010 : 4'b0000);
    end
    set_btn(4'b0001);
    for (int c = 1; c <= 20; c++) begin
      tick();
      chk_mv("held_rdy_mv", 4'b0000);
      chk("held_rdy_drop", {7'h0, bus.dropped}, (c == 7) ? 8'h01 : 8'h00);
    end
    set_btn(4'b0000);
    bus.ready = 1'b0;
    repeat (10) tick();
    chk("released_lvl", {4'h0, bus.btn_level}, 8'h00);
    bus.ready = 1'b1;
    tick();
    set_btn(4'b0001);
    for (int c = 1; c <= 12; c++) begin
      tick();
      chk_mv("rearm_u_mv", (c == 8) ? 4'b0001 : 4'b0000);
    end

    // reset in the middle of the D debounce; D held through reset
    do_reset();
    bus.ready = 1'b1;
    set_btn(4'b0010);
    for (int c = 1; c <= 3; c++) begin
      tick();
      chk_mv("pre_rst_mv", 4'b0000);
    end
    Reset_n = 1'b0;
    #1;
    chk_mv("mid_rst_mv", 4'b0000);
    chk("mid_rst_lvl", {4'h0, bus.btn_level}, 8'h00);
    chk("mid_rst_drop", {7'h0, bus.dropped}, 8'h00);
    tick();
    tick();
    Reset_n = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      chk_mv("post_rst_mv", 4'b0000);
      chk("post_rst_drop", {7'h0, bus.dropped}, 8'h00);
    end
    chk("post_rst_lvl", {4'h0, bus.btn_level}, 8'h02);
    set_btn(4'b0000);
    repeat (10) tick();
    set_btn(4'b0010);
    for (int c = 1; c <= 12; c++) begin
      tick();
      chk_mv("repress_d_mv", (c == 8) ? 4'b0010 : 4'b0000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
